// File: rtl/alu_pkg_hdl.sv
// ============================================================
// alu_pkg_hdl : shared op codes, FSM states and defaults for the ALU core
// Rev 1.0
// ============================================================
`default_nettype none

package alu_pkg_hdl;

   localparam int ALU_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      no_op  = 3'd0,
      add_op = 3'd1,
      and_op = 3'd2,
      xor_op = 3'd3,
      mul_op = 3'd4,
      rst_op = 3'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2
   } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core_mul_iter.sv
// ============================================================
// alu_core_mul_iter : iterative shift-add multiplier, one bit per cycle
// Rev 1.0
// ============================================================
`default_nettype none

module alu_core_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 last,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [2*WIDTH-1:0] partial;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   // product is the accumulator including the current bit, so on the last
   // iteration it already holds the full result.
   always_comb begin
      partial  = mplier_q[0] ? mcand_q : '0;
      product  = acc_q + partial;
      last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
      busy     = busy_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = product;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (last) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_core_seq.sv
// ============================================================
// alu_core_seq : sequential ALU, valid/ready in, done/result out
// Optional: ALU_CORE_STATUS_EN adds the overflow status port
// Rev 1.0
// ============================================================
`default_nettype none

module alu_core_seq
   import alu_pkg_hdl::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   output logic                 ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
`ifdef ALU_CORE_STATUS_EN
   ,
   output logic                 overflow
`endif
);

   alu_state_t         state_q, state_d;
   alu_op_t            op_q, op_d, op_in;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [2*WIDTH-1:0] sum;
   logic               accept;
   logic               mul_start, mul_busy, mul_last;
   logic [2*WIDTH-1:0] mul_product;
`ifdef ALU_CORE_STATUS_EN
   logic               ovf_q, ovf_d;
`endif

   assign op_in  = alu_op_t'(op);
   assign accept = valid && ready;
   assign sum    = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};

   alu_core_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= no_op;
         a_q      <= '0;
         b_q      <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
`ifdef ALU_CORE_STATUS_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         done_q   <= done_d;
         result_q <= result_d;
`ifdef ALU_CORE_STATUS_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op_in)
                  add_op, and_op, xor_op: state_d = EXEC;
                  mul_op:                 state_d = MUL;
                  default:                state_d = IDLE;
               endcase
            end
         end
         EXEC:    state_d = IDLE;
         MUL:     if (mul_last || !mul_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready     = (state_q == IDLE);
      mul_start = 1'b0;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      done_d    = 1'b0;
      result_d  = result_q;
`ifdef ALU_CORE_STATUS_EN
      ovf_d     = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = op_in;
               a_d       = a;
               b_d       = b;
               mul_start = (op_in == mul_op);
               if (op_in == rst_op) begin
                  result_d = '0;
`ifdef ALU_CORE_STATUS_EN
                  ovf_d    = 1'b0;
`endif
               end
            end
         end
         EXEC: begin
            done_d = 1'b1;
`ifdef ALU_CORE_STATUS_EN
            ovf_d  = 1'b0;
`endif
            case (op_q)
               add_op: begin
                  result_d = sum;
`ifdef ALU_CORE_STATUS_EN
                  ovf_d    = sum[WIDTH];
`endif
               end
               and_op:  result_d = {{WIDTH{1'b0}}, a_q & b_q};
               xor_op:  result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
               default: result_d = result_q;
            endcase
         end
         MUL: begin
            if (mul_last) begin
               done_d   = 1'b1;
               result_d = mul_product;
`ifdef ALU_CORE_STATUS_EN
               ovf_d    = |mul_product[2*WIDTH-1:WIDTH];
`endif
            end
         end
         default: ;
      endcase
   end

   assign done   = done_q;
   assign result = result_q;
`ifdef ALU_CORE_STATUS_EN
   assign overflow = ovf_q;
`endif

endmodule

`default_nettype wire
